// File: rtl/fetch_ctrl.sv
// fetch_ctrl: program counter sequencing, branch resolution and the
// architectural Z/N flag register for the accumulator core. It also provides
// a start/done handshake and a saturating count of execution cycles.
module fetch_ctrl #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PC_W-1:0]  start_addr,
    input  logic             is_jmp,
    input  logic             is_brz,
    input  logic             is_brn,
    input  logic             is_halt,
    input  logic [PC_W-1:0]  br_tgt,
    input  logic [7:0]       br_off,
    input  logic             flag_we,
    input  logic             alu_z,
    input  logic             alu_neg,
    output logic [PC_W-1:0]  pc,
    output logic             instr_valid,
    output logic             busy,
    output logic             done,
    output logic             z_flag,
    output logic             neg_flag,
    output logic [CNT_W-1:0] cycle_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              z_q, z_d;
    logic              neg_q, neg_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic signed [31:0] off_wide;
    logic [PC_W-1:0]    off_ext;
    logic [PC_W-1:0]    pc_inc;
    logic [PC_W-1:0]    pc_rel;
    logic               br_taken;
    logic [CNT_W-1:0]   cnt_inc;

    // Sign-extend the 8-bit offset through a wide intermediate so any PC_W
    // up to 32 works; the PC adders then wrap naturally modulo 2^PC_W.
    assign off_wide = 32'(signed'(br_off));
    assign off_ext  = off_wide[PC_W-1:0];
    assign pc_inc   = pc_q + PC_W'(1);
    assign pc_rel   = pc_q + off_ext;

    // Branches look at the flag register as it stood before this edge, so a
    // flag write in the same cycle only affects later branches.
    assign br_taken = (is_brz && z_q) || (is_brn && neg_q);

    // Saturating increment: stick at all-ones rather than wrapping.
    assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state, next-PC and counter decode for the fetch sequencer.
    always_comb begin
        // NOTE: every combinational output gets a default before the case so
        // no path leaves it unassigned, which would infer a latch.
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    pc_d    = start_addr;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                cnt_d = cnt_inc;
                if (is_halt) begin
                    state_d = S_HALT;
                end else if (is_jmp) begin
                    pc_d    = br_tgt;
                    state_d = S_FLUSH;
                end else if (br_taken) begin
                    pc_d    = pc_rel;
                    state_d = S_FLUSH;
                end else begin
                    pc_d    = pc_inc;
                end
            end
            S_FLUSH: begin
                cnt_d   = cnt_inc;
                state_d = S_RUN;
            end
            S_HALT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Flag register capture from the ALU, independent of sequencer state.
    always_comb begin
        z_d   = z_q;
        neg_d = neg_q;
        if (flag_we) begin
            z_d   = alu_z;
            neg_d = alu_neg;
        end
    end

    // State, PC, flag and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            z_q     <= 1'b0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from
            // the same pre-edge values regardless of statement order.
            state_q <= state_d;
            pc_q    <= pc_d;
            z_q     <= z_d;
            neg_q   <= neg_d;
            cnt_q   <= cnt_d;
        end
    end

    // Status outputs decode straight from registered state, so reset clears
    // them immediately and no input reaches them combinationally.
    assign instr_valid = (state_q == S_RUN);
    assign busy        = (state_q == S_RUN) || (state_q == S_FLUSH);
    assign done        = (state_q == S_HALT);
    assign pc          = pc_q;
    assign z_flag      = z_q;
    assign neg_flag    = neg_q;
    assign cycle_cnt   = cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios followed by random
// stimulus, all compared against a behavioural model of the fetch stage.
module tb_fetch_ctrl;

    localparam int PC_W = 10;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [PC_W-1:0] start_addr;
    logic            is_jmp, is_brz, is_brn, is_halt;
    logic [PC_W-1:0] br_tgt;
    logic [7:0]      br_off;
    logic            flag_we, alu_z, alu_neg;

    logic [PC_W-1:0] pc, pc4;
    logic            iv, iv4, busy, busy4, done, done4;
    logic            zf, zf4, nf, nf4;
    logic [15:0]     cnt;
    logic [3:0]      cnt4;

    int total = 0;
    int bad   = 0;

    // Behavioural model: running / bubble / halt-pulse flags, a raw cycle
    // count (saturation applied per instance when comparing).
    int m_pc;
    int m_cnt;
    bit m_active, m_bubble, m_done, m_z, m_n;

    fetch_ctrl #(.PC_W(PC_W), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .is_jmp(is_jmp), .is_brz(is_brz), .is_brn(is_brn), .is_halt(is_halt),
        .br_tgt(br_tgt), .br_off(br_off), .flag_we(flag_we), .alu_z(alu_z),
        .alu_neg(alu_neg), .pc(pc), .instr_valid(iv), .busy(busy), .done(done),
        .z_flag(zf), .neg_flag(nf), .cycle_cnt(cnt)
    );

    fetch_ctrl #(.PC_W(PC_W), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
        .is_jmp(is_jmp), .is_brz(is_brz), .is_brn(is_brn), .is_halt(is_halt),
        .br_tgt(br_tgt), .br_off(br_off), .flag_we(flag_we), .alu_z(alu_z),
        .alu_neg(alu_neg), .pc(pc4), .instr_valid(iv4), .busy(busy4), .done(done4),
        .z_flag(zf4), .neg_flag(nf4), .cycle_cnt(cnt4)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 0; m_cnt = 0;
        m_active = 0; m_bubble = 0; m_done = 0; m_z = 0; m_n = 0;
    endtask

    // One clock edge of the fetch stage, evaluated from the inputs presently
    // driven and the model state before the edge.
    task automatic model_step();
        int off;
        bit take;
        off  = int'($signed(br_off));
        take = (is_brz && m_z) || (is_brn && m_n);
        if (m_done) begin
            m_done = 0;
        end else if (!m_active) begin
            if (start) begin
                m_pc = int'(start_addr);
                m_cnt = 0;
                m_active = 1;
            end
        end else if (m_bubble) begin
            m_bubble = 0;
            m_cnt++;
        end else begin
            m_cnt++;
            if (is_halt) begin
                m_active = 0;
                m_done = 1;
            end else if (is_jmp) begin
                m_pc = int'(br_tgt);
                m_bubble = 1;
            end else if (take) begin
                m_pc = (((m_pc + off) % 1024) + 1024) % 1024;
                m_bubble = 1;
            end else begin
                m_pc = (m_pc + 1) % 1024;
            end
        end
        if (flag_we) begin
            m_z = alu_z;
            m_n = alu_neg;
        end
    endtask

    task automatic check_all(input string tag);
        int e16, e4;
        e16 = (m_cnt > 65535) ? 65535 : m_cnt;
        e4  = (m_cnt > 15) ? 15 : m_cnt;
        check({tag, ".pc"},    32'(pc),    32'(m_pc));
        check({tag, ".iv"},    32'(iv),    32'(m_active && !m_bubble));
        check({tag, ".busy"},  32'(busy),  32'(m_active));
        check({tag, ".done"},  32'(done),  32'(m_done));
        check({tag, ".z"},     32'(zf),    32'(m_z));
        check({tag, ".n"},     32'(nf),    32'(m_n));
        check({tag, ".cnt"},   32'(cnt),   32'(e16));
        check({tag, ".pc4"},   32'(pc4),   32'(m_pc));
        check({tag, ".iv4"},   32'(iv4),   32'(m_active && !m_bubble));
        check({tag, ".done4"}, 32'(done4), 32'(m_done));
        check({tag, ".cnt4"},  32'(cnt4),  32'(e4));
    endtask

    task automatic clear_in();
        start = 0; start_addr = '0;
        is_jmp = 0; is_brz = 0; is_brn = 0; is_halt = 0;
        br_tgt = '0; br_off = '0;
        flag_we = 0; alu_z = 0; alu_neg = 0;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        clear_in();
        model_reset();
        #3;
        check_all("por");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Start, run a little, then reset mid-RUN away from any edge.
        start = 1; start_addr = 10'h005;
        tick("pre_start");
        clear_in();
        tick("pre_run");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst_pc", 32'(pc), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Start at 0x010, then three plain cycles.
        start = 1; start_addr = 10'h010;
        tick("start");
        check("start_pc", 32'(pc), 32'h010);
        check("start_iv", 32'(iv), 32'h1);
        clear_in();
        repeat (3) tick("seq");
        check("seq_pc", 32'(pc), 32'h013);
        check("seq_cnt", 32'(cnt), 32'd3);

        // Taken BRZ: flag set at 0x01F, branch at 0x020 with offset -4.
        is_jmp = 1; br_tgt = 10'h01F;
        tick("jmp1f");
        clear_in();
        tick("flush1f");
        flag_we = 1; alu_z = 1;
        tick("setz");
        clear_in();
        is_brz = 1; br_off = 8'hFC;
        tick("brz_taken");
        check("brz_taken_pc", 32'(pc), 32'h01C);
        check("brz_bubble", 32'(iv), 32'h0);
        clear_in();
        tick("brz_after");
        check("brz_after_iv", 32'(iv), 32'h1);

        // Untaken BRZ with Z cleared.
        is_jmp = 1; br_tgt = 10'h01F;
        tick("jmp1f_b");
        clear_in();
        tick("flush1f_b");
        flag_we = 1; alu_z = 0;
        tick("clrz");
        clear_in();
        is_brz = 1; br_off = 8'hFC;
        tick("brz_untaken");
        check("brz_untaken_pc", 32'(pc), 32'h021);
        check("brz_untaken_iv", 32'(iv), 32'h1);

        // Same-cycle flag write must not steer the branch.
        flag_we = 1; alu_z = 1;
        tick("brz_same_cycle");
        check("brz_same_pc", 32'(pc), 32'h022);
        check("brz_same_z", 32'(zf), 32'h1);
        clear_in();

        // PC wrap on increment, then BRN wrapping below zero.
        is_jmp = 1; br_tgt = 10'h3FF;
        tick("jmp3ff");
        clear_in();
        tick("flush3ff");
        tick("wrap");
        check("wrap_pc", 32'(pc), 32'h000);
        flag_we = 1; alu_neg = 1;
        tick("setn");
        clear_in();
        tick("to2");
        is_brn = 1; br_off = 8'hF0;
        tick("brn_wrap");
        check("brn_wrap_pc", 32'(pc), 32'h3F2);
        clear_in();
        tick("brn_flush");

        // Absolute jump to 0x155: target appears, bubble, then live.
        is_jmp = 1; br_tgt = 10'h155;
        tick("jmp155");
        clear_in();
        tick("jmp155_live");
        check("jmp155_pc", 32'(pc), 32'h155);
        check("jmp155_iv", 32'(iv), 32'h1);

        // start during RUN is ignored.
        start = 1; start_addr = 10'h0AA;
        tick("start_in_run");
        check("start_in_run_pc", 32'(pc), 32'h156);
        clear_in();

        // Halt and jmp together: halt wins, single done pulse, back to IDLE.
        is_halt = 1; is_jmp = 1; br_tgt = 10'h100;
        tick("halt");
        check("halt_done", 32'(done), 32'h1);
        check("halt_pc", 32'(pc), 32'h156);
        clear_in();
        tick("halt_idle");
        check("halt_done_once", 32'(done), 32'h0);
        tick("idle_hold");

        // Restart: counter cleared, flags retained; then saturation run.
        start = 1; start_addr = 10'h200;
        tick("restart");
        check("restart_cnt", 32'(cnt), 32'h0);
        check("restart_n", 32'(nf), 32'h1);
        clear_in();
        repeat (20) tick("sat_run");
        check("sat_cnt4", 32'(cnt4), 32'd15);
        check("sat_cnt16", 32'(cnt), 32'd20);
        tick("sat_hold");
        check("sat_cnt4_hold", 32'(cnt4), 32'd15);
        is_halt = 1;
        tick("halt2");
        clear_in();
        tick("halt2_idle");

        // Random stimulus against the model.
        for (int i = 0; i < 400; i++) begin
            start      = ($urandom_range(0, 3) == 0);
            start_addr = PC_W'($urandom);
            is_halt    = ($urandom_range(0, 19) == 0);
            is_jmp     = ($urandom_range(0, 7) == 0);
            is_brz     = ($urandom_range(0, 3) == 0);
            is_brn     = ($urandom_range(0, 3) == 0);
            br_tgt     = PC_W'($urandom);
            br_off     = 8'($urandom);
            flag_we    = ($urandom_range(0, 2) == 0);
            alu_z      = 1'($urandom);
            alu_neg    = 1'($urandom);
            tick("rand");
        end
        clear_in();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
